lc3_control_fsm: RTL
====================

# lc3_control_fsm

Multi-cycle control unit for the LC-3 datapath. Consumes the instruction register contents and NZP condition flags the datapath exports, and drives every datapath select, bus enable, load strobe and write enable so that each instruction runs fetch, decode and execute as a fixed state sequence. It is the sequencing counterpart of the datapath; together the two form the complete LC-3 core.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- IR  input  16  current instruction register value from the datapath
- N, Z, P  input  1 each  condition flags from the datapath
- aluControl  output  2  0=pass Ra, 1=ADD, 2=AND, 3=NOT
- SR1, SR2, DR  output  3 each  register file read/write addresses
- selPC  output  2  0=PC+1, 1=eabOut, 2=Buss
- selEAB1  output  1  0=PC, 1=Ra
- selEAB2  output  2  0=zero, 1=sext IR[5:0], 2=sext IR[8:0], 3=sext IR[10:0]
- selMAR  output  1  0=eabOut, 1=zext IR[7:0]
- selMDR  output  1  0=Buss, 1=memory read data
- enaALU, enaMARM, enaPC, enaMDR  output  1 each  tri-state Buss drivers; at most one high per cycle
- ldPC, ldIR, ldMAR, ldMDR  output  1 each  register load strobes
- regWE, flagWE, memWE  output  1 each  register file, NZP and memory write enables
- halted  output  1  high while in HALT

## Operation
- Moore FSM; outputs are a combinational decode of the state register plus IR fields. Any signal not listed for a state is 0.
- FETCH0: enaPC, ldMAR, ldPC, selPC=0.
- FETCH1: ldMDR, selMDR=1.
- FETCH2: enaMDR, ldIR.
- DECODE: no strobes; next state selected from IR[15:12].
- ALU (ADD 0001, AND 0101, NOT 1001): enaALU, regWE, flagWE, DR=IR[11:9], SR1=IR[8:6], SR2=IR[2:0], aluControl=1/2/3.
- BR (0000): if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), assert ldPC, selPC=1, selEAB1=0, selEAB2=2; otherwise no strobes.
- JMP (1100): ldPC, selPC=1, selEAB1=1, selEAB2=0, SR1=IR[8:6].
- JSR (0100): JSR0 enaPC, regWE, DR=7; JSR1 ldPC, selPC=1; IR[11]=1 uses selEAB1=0, selEAB2=3; IR[11]=0 uses selEAB1=1, selEAB2=0, SR1=IR[8:6]. JSRR R7 therefore jumps to the just-written return address (defined behaviour).
- ADDR (LD 0010, ST 0011, LDI 1010, STI 1011, LDR 0110, STR 0111): enaMARM, selMAR=0, ldMAR. PC-relative ops use selEAB1=0, selEAB2=2. LDR/STR use selEAB1=1, selEAB2=1, SR1=IR[8:6].
- LDI/STI only: IND0 ldMDR, selMDR=1; IND1 enaMDR, ldMAR.
- Loads: LD0 ldMDR, selMDR=1; LD1 enaMDR, regWE, flagWE, DR=IR[11:9].
- Stores: ST0 enaALU, aluControl=0, SR1=IR[11:9], ldMDR, selMDR=0; ST1 memWE.
- LEA (1110): enaMARM, selMAR=0, selEAB1=0, selEAB2=2, regWE, DR=IR[11:9]; flags unchanged.
- RTI (1000) and reserved (1101) → HALT. HALT: all strobes 0, halted=1, held until reset.
- Every terminal execute state returns to FETCH0.

## Timing
- Reset low: state=FETCH0 immediately; all strobes, enables and halted forced to 0 while reset is low.
- First FETCH0 strobes appear in the first cycle after reset deasserts.
- Cycles per instruction (fetch+decode included): ALU/BR/JMP/LEA 5, JSR 6, LD/LDR/ST/STR 7, LDI/STI 9, TRAP 8.
- Memory contract: MDR captures mem[MAR] at the edge ending a selMDR=1 ldMDR cycle; memWE writes MDR to mem[MAR] at that cycle's edge.
- Branch condition is sampled from N/Z/P during the BR state.
- Reset asserted mid-instruction aborts it; no partial write completes after reset asserts.

## Configuration
- LC3_TRAP_EN defined: TRAP (1111) executes TRAP0 enaPC, regWE, DR=7; TRAP1 enaMARM, selMAR=1, ldMAR; TRAP2 ldMDR, selMDR=1; TRAP3 enaMDR, ldPC, selPC=2.
- Undefined: opcode 1111 → HALT.

## Test plan
- Reset low for 3 cycles, then high → all outputs 0 during reset; cycle 1 after release shows enaPC=ldMAR=ldPC=1.
- IR=0x1265 (ADD R1,R1,#5) → 5th cycle: enaALU, regWE, flagWE, aluControl=1, DR=1, SR1=1; next cycle FETCH0.
- IR=0x0402 (BRz) with Z=1 → ldPC, selPC=1, selEAB2=2; repeat with Z=0 → no ldPC.
- IR=0xA203 (LDI R1) → exactly 9 cycles; IND1 asserts enaMDR+ldMAR; LD1 asserts regWE with DR=1.
- IR=0x7442 (STR R2,R1,#2) → ADDR selEAB1=1, selEAB2=1, SR1=1; ST0 SR1=2, selMDR=0; ST1 memWE=1.
- IR=0xF025 → halted=1 with LC3_TRAP_EN undefined; with it defined, TRAP0 DR=7, TRAP1 selMAR=1, TRAP3 selPC=2, back to FETCH0 after 8 cycles.

Source files
------------

// File: rtl/lc3_control_fsm.sv
// Multi-cycle LC-3 control unit: fetch/decode/execute sequencing driving datapath strobes.
// Optional macro LC3_TRAP_EN adds the TRAP sequence; otherwise opcode 1111 halts.
module lc3_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic [1:0]  aluControl,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic [1:0]  selPC,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        selMAR,
    output logic        selMDR,
    output logic        enaALU,
    output logic        enaMARM,
    output logic        enaPC,
    output logic        enaMDR,
    output logic        ldPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        regWE,
    output logic        flagWE,
    output logic        memWE,
    output logic        halted
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_BR   = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_LD   = 4'h2;
    localparam logic [OP_W-1:0] OP_ST   = 4'h3;
    localparam logic [OP_W-1:0] OP_JSR  = 4'h4;
    localparam logic [OP_W-1:0] OP_AND  = 4'h5;
    localparam logic [OP_W-1:0] OP_LDR  = 4'h6;
    localparam logic [OP_W-1:0] OP_STR  = 4'h7;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h9;
    localparam logic [OP_W-1:0] OP_LDI  = 4'hA;
    localparam logic [OP_W-1:0] OP_STI  = 4'hB;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
    localparam logic [OP_W-1:0] OP_LEA  = 4'hE;
`ifdef LC3_TRAP_EN
    localparam logic [OP_W-1:0] OP_TRAP = 4'hF;
`endif

    typedef enum logic [4:0] {
        S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_ALU, S_BR, S_JMP, S_JSR0, S_JSR1,
        S_ADDR, S_IND0, S_IND1, S_LD0, S_LD1, S_ST0, S_ST1, S_LEA,
`ifdef LC3_TRAP_EN
        S_TRAP0, S_TRAP1, S_TRAP2, S_TRAP3,
`endif
        S_HALT
    } state_t;

    state_t state_q, state_d;

    logic [OP_W-1:0] opcode;
    logic            br_take;
    logic            mem_ind;
    logic            mem_store;
    logic            mem_base;
    logic            unused_ir;

    assign opcode    = IR[15:12];
    assign br_take   = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
    // Memory-op class bits: IR[15] indirect, IR[12] store, IR[14] base+offset.
    assign mem_ind   = IR[15];
    assign mem_store = IR[12];
    assign mem_base  = IR[14];
    assign unused_ir = ^IR[5:3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH0;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        aluControl = 2'd0;
        SR1        = 3'd0;
        SR2        = 3'd0;
        DR         = 3'd0;
        selPC      = 2'd0;
        selEAB1    = 1'b0;
        selEAB2    = 2'd0;
        selMAR     = 1'b0;
        selMDR     = 1'b0;
        enaALU     = 1'b0;
        enaMARM    = 1'b0;
        enaPC      = 1'b0;
        enaMDR     = 1'b0;
        ldPC       = 1'b0;
        ldIR       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        regWE      = 1'b0;
        flagWE     = 1'b0;
        memWE      = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_FETCH0: begin
                enaPC = 1'b1; ldMAR = 1'b1; ldPC = 1'b1;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                state_d = S_FETCH2;
            end
            S_FETCH2: begin
                enaMDR = 1'b1; ldIR = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT:                 state_d = S_ALU;
                    OP_BR:                                  state_d = S_BR;
                    OP_JMP:                                 state_d = S_JMP;
                    OP_JSR:                                 state_d = S_JSR0;
                    OP_LEA:                                 state_d = S_LEA;
                    OP_LD, OP_ST, OP_LDI, OP_STI, OP_LDR, OP_STR: state_d = S_ADDR;
`ifdef LC3_TRAP_EN
                    OP_TRAP:                                state_d = S_TRAP0;
`endif
                    default:                                state_d = S_HALT;
                endcase
            end
            S_ALU: begin
                enaALU = 1'b1; regWE = 1'b1; flagWE = 1'b1;
                DR = IR[11:9]; SR1 = IR[8:6]; SR2 = IR[2:0];
                if (opcode == OP_ADD)      aluControl = 2'd1;
                else if (opcode == OP_AND) aluControl = 2'd2;
                else                       aluControl = 2'd3;
                state_d = S_FETCH0;
            end
            S_BR: begin
                if (br_take) begin
                    ldPC = 1'b1; selPC = 2'd1; selEAB2 = 2'd2;
                end
                state_d = S_FETCH0;
            end
            S_JMP: begin
                ldPC = 1'b1; selPC = 2'd1; selEAB1 = 1'b1; SR1 = IR[8:6];
                state_d = S_FETCH0;
            end
            S_JSR0: begin
                enaPC = 1'b1; regWE = 1'b1; DR = 3'd7;
                state_d = S_JSR1;
            end
            S_JSR1: begin
                ldPC = 1'b1; selPC = 2'd1;
                if (IR[11]) begin
                    selEAB2 = 2'd3;
                end else begin
                    selEAB1 = 1'b1; SR1 = IR[8:6];
                end
                state_d = S_FETCH0;
            end
            S_ADDR: begin
                enaMARM = 1'b1; ldMAR = 1'b1;
                if (mem_base) begin
                    selEAB1 = 1'b1; selEAB2 = 2'd1; SR1 = IR[8:6];
                end else begin
                    selEAB2 = 2'd2;
                end
                if (mem_ind)        state_d = S_IND0;
                else if (mem_store) state_d = S_ST0;
                else                state_d = S_LD0;
            end
            S_IND0: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                state_d = S_IND1;
            end
            S_IND1: begin
                enaMDR = 1'b1; ldMAR = 1'b1;
                state_d = mem_store ? S_ST0 : S_LD0;
            end
            S_LD0: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                state_d = S_LD1;
            end
            S_LD1: begin
                enaMDR = 1'b1; regWE = 1'b1; flagWE = 1'b1; DR = IR[11:9];
                state_d = S_FETCH0;
            end
            S_ST0: begin
                enaALU = 1'b1; SR1 = IR[11:9]; ldMDR = 1'b1;
                state_d = S_ST1;
            end
            S_ST1: begin
                memWE = 1'b1;
                state_d = S_FETCH0;
            end
            S_LEA: begin
                enaMARM = 1'b1; selEAB2 = 2'd2; regWE = 1'b1; DR = IR[11:9];
                state_d = S_FETCH0;
            end
`ifdef LC3_TRAP_EN
            S_TRAP0: begin
                enaPC = 1'b1; regWE = 1'b1; DR = 3'd7;
                state_d = S_TRAP1;
            end
            S_TRAP1: begin
                enaMARM = 1'b1; selMAR = 1'b1; ldMAR = 1'b1;
                state_d = S_TRAP2;
            end
            S_TRAP2: begin
                ldMDR = 1'b1; selMDR = 1'b1;
                state_d = S_TRAP3;
            end
            S_TRAP3: begin
                enaMDR = 1'b1; ldPC = 1'b1; selPC = 2'd2;
                state_d = S_FETCH0;
            end
`endif
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH0;
            end
        endcase

        // Reset holds the state at FETCH0; suppress its strobes until release.
        if (!reset) begin
            {aluControl, SR1, SR2, DR, selPC, selEAB1, selEAB2, selMAR, selMDR,
             enaALU, enaMARM, enaPC, enaMDR, ldPC, ldIR, ldMAR, ldMDR,
             regWE, flagWE, memWE, halted} = '0;
        end
    end

endmodule
